// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Bundles the opcode and memory-ready inputs of the multicycle
//                controller together with every control output it decodes.
//                master : the controller (drives control, samples op/mem_ready)
//                slave  : the datapath  (drives op/mem_ready, samples control)
//  Signals     : op[5:0], mem_ready           - datapath to controller
//                pcwrite, branch, iord, memread, memwrite, irwrite, regdst,
//                memtoreg, regwrite, alusrca, illegal,
//                alusrcb[1:0], aluop[1:0], pcsrc[1:0], state[3:0]
//                                             - controller to datapath
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic       illegal;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic [3:0] state;

    modport master (
        input  op, mem_ready,
        output pcwrite, branch, iord, memread, memwrite, irwrite, regdst,
               memtoreg, regwrite, alusrca, illegal, alusrcb, aluop, pcsrc,
               state
    );

    modport slave (
        output op, mem_ready,
        input  pcwrite, branch, iord, memread, memwrite, irwrite, regdst,
               memtoreg, regwrite, alusrca, illegal, alusrcb, aluop, pcsrc,
               state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multicycle CPU main control FSM. Sequences fetch, decode,
//                memory, ALU, branch, ADDI, jump and illegal-opcode handling,
//                decoding all datapath controls from the current state.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous active-high reset
//                bus    - multicycle_ctrl_if.master (op, mem_ready in;
//                         control signals and debug state out)
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
    input  wire                   clk,
    input  wire                   reset,
    multicycle_ctrl_if.master     bus
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_MEMADR = 4'd2;
    localparam logic [3:0] c_MEMRD  = 4'd3;
    localparam logic [3:0] c_MEMWB  = 4'd4;
    localparam logic [3:0] c_MEMWR  = 4'd5;
    localparam logic [3:0] c_EXEC   = 4'd6;
    localparam logic [3:0] c_ALUWB  = 4'd7;
    localparam logic [3:0] c_BRANCH = 4'd8;
    localparam logic [3:0] c_ADDIEX = 4'd9;
    localparam logic [3:0] c_ADDIWB = 4'd10;
    localparam logic [3:0] c_JUMP   = 4'd11;
    localparam logic [3:0] c_ILL    = 4'd12;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    logic [3:0] r_state;
    logic [3:0] w_next;

    logic       w_pcwrite, w_branch, w_iord, w_memread, w_memwrite, w_irwrite;
    logic       w_regdst, w_memtoreg, w_regwrite, w_alusrca, w_illegal;
    logic [1:0] w_alusrcb, w_aluop, w_pcsrc;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; mem_ready only matters in FETCH, MEMRD and MEMWR
    always_comb begin
        w_next = c_FETCH;
        case (r_state)
            c_FETCH:  w_next = bus.mem_ready ? c_DECODE : c_FETCH;
            c_DECODE: begin
                case (bus.op)
                    c_OP_LW, c_OP_SW: w_next = c_MEMADR;
                    c_OP_RTYPE:       w_next = c_EXEC;
                    c_OP_BEQ:         w_next = c_BRANCH;
                    c_OP_ADDI:        w_next = c_ADDIEX;
                    c_OP_J:           w_next = c_JUMP;
                    default:          w_next = c_ILL;
                endcase
            end
            // op is stable here and already known to be LW or SW
            c_MEMADR: w_next = (bus.op == c_OP_LW) ? c_MEMRD : c_MEMWR;
            c_MEMRD:  w_next = bus.mem_ready ? c_MEMWB : c_MEMRD;
            c_MEMWR:  w_next = bus.mem_ready ? c_FETCH : c_MEMWR;
            c_EXEC:   w_next = c_ALUWB;
            c_ADDIEX: w_next = c_ADDIWB;
            // MEMWB, ALUWB, BRANCH, ADDIWB, JUMP, ILL and the unused
            // encodings 13..15 all return to FETCH
            default:  w_next = c_FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_iord     = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_illegal  = 1'b0;
        w_alusrcb  = 2'b00;
        w_aluop    = 2'b00;
        w_pcsrc    = 2'b00;
        case (r_state)
            c_FETCH: begin
                w_memread = 1'b1;
                w_alusrcb = 2'b01;
                // PC+1 and IR load only commit on the cycle memory delivers
                w_irwrite = bus.mem_ready;
                w_pcwrite = bus.mem_ready;
            end
            c_DECODE: w_alusrcb = 2'b11;
            c_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            c_MEMRD: begin
                w_iord    = 1'b1;
                w_memread = 1'b1;
            end
            c_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            c_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
            end
            c_EXEC: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
            end
            c_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            c_BRANCH: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b01;
                w_branch  = 1'b1;
                w_pcsrc   = 2'b01;
            end
            c_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            c_ADDIWB: w_regwrite = 1'b1;
            c_JUMP: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
            end
            c_ILL:    w_illegal = 1'b1;
            default:  ;
        endcase
        // During reset present a write-free FETCH so nothing architectural
        // changes, including a store that was waiting in MEMWR
        if (reset) begin
            w_pcwrite  = 1'b0;
            w_branch   = 1'b0;
            w_iord     = 1'b0;
            w_memread  = 1'b1;
            w_memwrite = 1'b0;
            w_irwrite  = 1'b0;
            w_regdst   = 1'b0;
            w_memtoreg = 1'b0;
            w_regwrite = 1'b0;
            w_alusrca  = 1'b0;
            w_illegal  = 1'b0;
            w_alusrcb  = 2'b01;
            w_aluop    = 2'b00;
            w_pcsrc    = 2'b00;
        end
    end

    assign bus.pcwrite  = w_pcwrite;
    assign bus.branch   = w_branch;
    assign bus.iord     = w_iord;
    assign bus.memread  = w_memread;
    assign bus.memwrite = w_memwrite;
    assign bus.irwrite  = w_irwrite;
    assign bus.regdst   = w_regdst;
    assign bus.memtoreg = w_memtoreg;
    assign bus.regwrite = w_regwrite;
    assign bus.alusrca  = w_alusrca;
    assign bus.illegal  = w_illegal;
    assign bus.alusrcb  = w_alusrcb;
    assign bus.aluop    = w_aluop;
    assign bus.pcsrc    = w_pcsrc;
    assign bus.state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Scoreboard bench for multicycle_ctrl. The stimulus process
//                drives one directed vector per cycle and queues the expected
//                state and control word; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pcwrite, branch, iord, memread, memwrite, irwrite;
        logic       regdst, memtoreg, regwrite, alusrca, illegal;
        logic [1:0] alusrcb, aluop, pcsrc;
    } ctl_t;

    typedef struct packed {
        logic [3:0] st;
        ctl_t       ctl;
    } exp_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t  sb[$];
    string nm[$];

    multicycle_ctrl_if u_if ();

    multicycle_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for a state, written straight from the state table
    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic mr,
                                     input logic rst_v);
        ctl_t c;
        c = '0;
        if (rst_v) begin
            c.memread = 1'b1;
            c.alusrcb = 2'b01;
            return c;
        end
        case (st)
            4'd0:  begin c.memread = 1'b1; c.alusrcb = 2'b01;
                         c.irwrite = mr; c.pcwrite = mr; end
            4'd1:  c.alusrcb = 2'b11;
            4'd2:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            4'd3:  begin c.iord = 1'b1; c.memread = 1'b1; end
            4'd4:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            4'd5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
            4'd6:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            4'd7:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            4'd8:  begin c.alusrca = 1'b1; c.aluop = 2'b01;
                         c.branch = 1'b1; c.pcsrc = 2'b01; end
            4'd9:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            4'd10: c.regwrite = 1'b1;
            4'd11: begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            4'd12: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // One cycle: drive inputs just after the edge, queue what must be seen
    task automatic step(input logic rst_v, input logic [5:0] op_v,
                        input logic mr_v, input logic [3:0] st_exp,
                        input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst_v;
        u_if.op        = op_v;
        u_if.mem_ready = mr_v;
        e.st  = st_exp;
        e.ctl = exp_ctl(st_exp, mr_v, rst_v);
        sb.push_back(e);
        nm.push_back(name);
    endtask

    // n cycles; sts holds one expected state per nibble (cycle 0 in the LSB),
    // mrs holds mem_ready per cycle (cycle 0 in bit 0)
    task automatic run(input logic [5:0] op_v, input int n,
                       input logic [63:0] sts, input logic [15:0] mrs,
                       input string name);
        for (int i = 0; i < n; i++) begin
            step(1'b0, op_v, mrs[i], sts[4*i +: 4], name);
        end
    endtask

    // Monitor: every cycle the controller presents a state and control word
    always @(negedge clk) begin
        exp_t  e;
        string n;
        ctl_t  act;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n = nm.pop_front();
            act = {u_if.pcwrite, u_if.branch, u_if.iord, u_if.memread,
                   u_if.memwrite, u_if.irwrite, u_if.regdst, u_if.memtoreg,
                   u_if.regwrite, u_if.alusrca, u_if.illegal, u_if.alusrcb,
                   u_if.aluop, u_if.pcsrc};
            checks++;
            if (u_if.state !== e.st) begin
                failures++;
                $display("FAIL %s state @%0t: got %0d expected %0d",
                         n, $time, u_if.state, e.st);
            end
            checks++;
            if (act !== e.ctl) begin
                failures++;
                $display("FAIL %s ctl (st %0d) @%0t: got %b expected %b",
                         n, e.st, $time, act, e.ctl);
            end
        end
    end

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        u_if.op        = OP_RTYPE;
        u_if.mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held: write-free FETCH decode
        step(1'b1, OP_RTYPE, 1'b1, 4'd0, "reset");
        // LW, no waits: 0,1,2,3,4 (5 cycles)
        run(OP_LW,    5, 64'h43210,   16'hFFFF, "lw");
        // SW with 2 wait cycles in MEMWR: 0,1,2,5,5,5 (6 cycles)
        run(OP_SW,    6, 64'h555210,  16'h0027, "sw_wait");
        // Fetch wait 3 cycles, then R-type: 0,0,0,0,1,6,7
        run(OP_RTYPE, 7, 64'h7610000, 16'h0078, "fetch_wait_rtype");
        run(OP_BEQ,   3, 64'h810,     16'hFFFF, "beq");
        run(OP_J,     3, 64'hB10,     16'hFFFF, "jump");
        run(OP_ADDI,  4, 64'hA910,    16'hFFFF, "addi");
        run(OP_BAD,   3, 64'hC10,     16'hFFFF, "illegal");
        // LW with one MEMRD wait: 0,1,2,3,3,4
        run(OP_LW,    6, 64'h433210,  16'h0037, "lw_wait");
        // SW stalled in MEMWR, then reset mid-wait
        run(OP_SW,    5, 64'h55210,   16'h0007, "sw_pre_reset");
        step(1'b1, OP_SW, 1'b0, 4'd5, "reset_in_memwr");
        step(1'b0, OP_SW, 1'b0, 4'd0, "after_reset");
        // First FETCH after reset behaves normally
        run(OP_BEQ,   3, 64'h810,     16'hFFFF, "beq_after_reset");
        step(1'b0, OP_RTYPE, 1'b0, 4'd0, "final_fetch");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left expected 0",
                     sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
